// File: rtl/estagio_operandos_soma_if.sv
// Bus between the control unit / Somador and the operand stage.
// slave = operand stage side, master = control unit + Somador side.
interface estagio_operandos_soma_if #(
  parameter int LARGURA  = 8,
  parameter int END_BITS = 3
);
  logic                Valido;
  logic [END_BITS-1:0] Rd;
  logic [END_BITS-1:0] Rs;
  logic [END_BITS-1:0] Rt;
  logic                Carga;
  logic [END_BITS-1:0] EndCarga;
  logic [LARGURA-1:0]  DadoCarga;
  logic [END_BITS-1:0] EndLeitura;
  logic [LARGURA-1:0]  DadoLeitura;
  logic [LARGURA-1:0]  Entrada1;
  logic [LARGURA-1:0]  Entrada2;
  logic [LARGURA-1:0]  Resultado;
  logic                Ocupado;
  logic                Pronto;
  logic                Overflow;

  modport slave (
    input  Valido, Rd, Rs, Rt, Carga, EndCarga, DadoCarga, EndLeitura, Resultado,
    output DadoLeitura, Entrada1, Entrada2, Ocupado, Pronto, Overflow
  );

  modport master (
    output Valido, Rd, Rs, Rt, Carga, EndCarga, DadoCarga, EndLeitura, Resultado,
    input  DadoLeitura, Entrada1, Entrada2, Ocupado, Pronto, Overflow
  );
endinterface

// File: rtl/estagio_operandos_soma.sv
// Register file + operand sequencer feeding the combinational Somador.
// One add takes four states; R0 is hardwired to zero.
module estagio_operandos_soma #(
  parameter int LARGURA  = 8,
  parameter int NUM_REGS = 8,
  parameter int END_BITS = 3
) (
  input logic                     Clock,
  input logic                     Reset,
  estagio_operandos_soma_if.slave bus
);

  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] LEITURA  = 2'd1;
  localparam logic [1:0] EXECUCAO = 2'd2;
  localparam logic [1:0] ESCRITA  = 2'd3;

  logic [1:0]          estado;
  logic [LARGURA-1:0]  regs [NUM_REGS];
  logic [END_BITS-1:0] rd_q, rs_q, rt_q;
  logic [LARGURA-1:0]  ent1_q, ent2_q, res_q;
  logic                ov_next_q, ov_q, pronto_q;
  logic                ov_calc;

  // signed overflow: like-signed operands giving a result of the other sign
  assign ov_calc = (ent1_q[LARGURA-1] == ent2_q[LARGURA-1]) &&
                   (bus.Resultado[LARGURA-1] != ent1_q[LARGURA-1]);

  // sequencer; Carga wins over Valido in idle and drops the request
  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado <= OCIOSO;
      rd_q   <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (!bus.Carga && bus.Valido) begin
            rd_q   <= bus.Rd;
            rs_q   <= bus.Rs;
            rt_q   <= bus.Rt;
            estado <= LEITURA;
          end
        end
        LEITURA:  estado <= EXECUCAO;
        EXECUCAO: estado <= ESCRITA;
        default:  estado <= OCIOSO;
      endcase
    end
  end

  // register file: direct load when idle, write-back in ESCRITA, R0 never written
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (estado == OCIOSO) begin
      if (bus.Carga && bus.EndCarga != '0) regs[bus.EndCarga] <= bus.DadoCarga;
    end else if (estado == ESCRITA) begin
      if (rd_q != '0) regs[rd_q] <= res_q;
    end
  end

  // operand fetch and result capture; operands hold until the next fetch
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ent1_q    <= '0;
      ent2_q    <= '0;
      res_q     <= '0;
      ov_next_q <= 1'b0;
    end else if (estado == LEITURA) begin
      ent1_q <= (rs_q == '0) ? '0 : regs[rs_q];
      ent2_q <= (rt_q == '0) ? '0 : regs[rt_q];
    end else if (estado == EXECUCAO) begin
      res_q     <= bus.Resultado;
      ov_next_q <= ov_calc;
    end
  end

  // completion flags: Pronto pulses one cycle, Overflow held until next completion
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pronto_q <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      pronto_q <= (estado == ESCRITA);
      if (estado == ESCRITA) ov_q <= ov_next_q;
    end
  end

  assign bus.DadoLeitura = (bus.EndLeitura == '0) ? '0 : regs[bus.EndLeitura];
  assign bus.Entrada1    = ent1_q;
  assign bus.Entrada2    = ent2_q;
  assign bus.Ocupado     = (estado != OCIOSO);
  assign bus.Pronto      = pronto_q;
  assign bus.Overflow    = ov_q;

endmodule

// File: tb/tb_estagio_operandos_soma.sv
// Directed bench with a scoreboard of expected write-backs; Somador modelled inline.
module tb_estagio_operandos_soma;

  logic Clock = 1'b0;
  logic Reset;

  estagio_operandos_soma_if #(.LARGURA(8), .END_BITS(3)) bus ();

  estagio_operandos_soma #(.LARGURA(8), .NUM_REGS(8), .END_BITS(3)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  // Somador: wrapping 8-bit adder
  assign bus.Resultado = bus.Entrada1 + bus.Entrada2;

  always #5 Clock = ~Clock;

  typedef struct {
    int         rd;
    logic [7:0] val;
    logic       ov;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m [8];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic rd_reg(input int a, output logic [7:0] v);
    bus.EndLeitura = 3'(a);
    #1;
    v = bus.DadoLeitura;
  endtask

  task automatic check_all_regs(input string tag);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) begin
      rd_reg(i, v);
      chk(tag, 32'(v), 32'(m[i]));
    end
  endtask

  task automatic load(input int a, input logic [7:0] d);
    bus.Carga     = 1'b1;
    bus.EndCarga  = 3'(a);
    bus.DadoCarga = d;
    tick();
    bus.Carga = 1'b0;
    if (a != 0) m[a] = d;
  endtask

  // issue one add; poke drives Valido+Carga while the stage is in LEITURA
  task automatic do_op(input int d, input int s, input int t, input bit poke);
    logic [7:0] a, b, sm, v;
    exp_t       e;
    int         cnt;
    a = m[s];
    b = m[t];
    sm = a + b;
    e.rd  = d;
    e.val = (d == 0) ? 8'h00 : sm;
    e.ov  = (a[7] == b[7]) && (sm[7] != a[7]);
    if (d != 0) m[d] = sm;
    sb.push_back(e);
    bus.Valido = 1'b1;
    bus.Rd = 3'(d);
    bus.Rs = 3'(s);
    bus.Rt = 3'(t);
    tick();
    bus.Valido = 1'b0;
    chk("ocupado_aceite", 32'(bus.Ocupado), 32'd1);
    if (poke) begin
      bus.Valido    = 1'b1;
      bus.Rd        = 3'd6;
      bus.Carga     = 1'b1;
      bus.EndCarga  = 3'd5;
      bus.DadoCarga = 8'h77;
    end
    tick();
    bus.Valido = 1'b0;
    bus.Carga  = 1'b0;
    chk("entrada1", 32'(bus.Entrada1), 32'(a));
    chk("entrada2", 32'(bus.Entrada2), 32'(b));
    cnt = 0;
    while (!bus.Pronto && cnt < 8) begin
      tick();
      cnt++;
    end
    chk("latencia", 32'(cnt), 32'd2);
    if (bus.Pronto) begin
      e = sb.pop_front();
      rd_reg(e.rd, v);
      chk("writeback", 32'(v), 32'(e.val));
      chk("overflow", 32'(bus.Overflow), 32'(e.ov));
      chk("ocioso_pronto", 32'(bus.Ocupado), 32'd0);
    end else begin
      chk("pronto_timeout", 32'(bus.Pronto), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] v;
    bit         seen;
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    Reset = 1'b1;
    bus.Valido = 1'b0;  bus.Rd = '0; bus.Rs = '0; bus.Rt = '0;
    bus.Carga = 1'b0;   bus.EndCarga = '0; bus.DadoCarga = '0;
    bus.EndLeitura = '0;
    tick();
    tick();
    Reset = 1'b0;

    // reset state
    chk("rst_ocupado", 32'(bus.Ocupado), 32'd0);
    chk("rst_pronto", 32'(bus.Pronto), 32'd0);
    chk("rst_overflow", 32'(bus.Overflow), 32'd0);
    chk("rst_entrada1", 32'(bus.Entrada1), 32'd0);
    chk("rst_entrada2", 32'(bus.Entrada2), 32'd0);
    check_all_regs("rst_regs");

    // basic add, then Pronto must drop after one cycle
    load(1, 8'd5);
    load(2, 8'd3);
    do_op(3, 1, 2, 1'b0);
    rd_reg(3, v);
    chk("basico_r3", 32'(v), 32'd8);
    tick();
    chk("pronto_pulso", 32'(bus.Pronto), 32'd0);

    // signed overflow cases
    load(1, 8'h7F);
    load(2, 8'h01);
    do_op(4, 1, 2, 1'b0);
    rd_reg(4, v);
    chk("ov_pos_r4", 32'(v), 32'h80);
    chk("ov_pos_flag", 32'(bus.Overflow), 32'd1);
    load(1, 8'h80);
    load(2, 8'hFF);
    do_op(4, 1, 2, 1'b0);
    rd_reg(4, v);
    chk("ov_neg_r4", 32'(v), 32'h7F);
    chk("ov_neg_flag", 32'(bus.Overflow), 32'd1);
    load(1, 8'hFE);
    load(2, 8'h05);
    do_op(4, 1, 2, 1'b0);
    rd_reg(4, v);
    chk("no_ov_r4", 32'(v), 32'h03);
    chk("no_ov_flag", 32'(bus.Overflow), 32'd0);

    // R0 hardwired zero
    load(0, 8'h55);
    rd_reg(0, v);
    chk("r0_carga", 32'(v), 32'd0);
    do_op(0, 1, 1, 1'b0);
    check_all_regs("r0_destino");
    load(2, 8'd9);
    do_op(5, 0, 2, 1'b0);
    rd_reg(5, v);
    chk("r0_fonte", 32'(v), 32'd9);

    // back-to-back dependency, each op issued in the previous Pronto cycle
    load(1, 8'd1);
    load(2, 8'd1);
    do_op(1, 1, 2, 1'b0);
    do_op(1, 1, 2, 1'b0);
    do_op(1, 1, 2, 1'b0);
    rd_reg(1, v);
    chk("dep_r1", 32'(v), 32'd4);

    // Valido/Carga while busy are ignored
    do_op(7, 1, 2, 1'b1);
    tick();
    chk("ocupado_ignorado", 32'(bus.Ocupado), 32'd0);
    check_all_regs("carga_ignorada");

    // Carga wins over Valido in idle; op dropped
    bus.Valido = 1'b1;
    bus.Rd = 3'd7; bus.Rs = 3'd1; bus.Rt = 3'd1;
    load(6, 8'h42);
    bus.Valido = 1'b0;
    chk("prio_ocupado", 32'(bus.Ocupado), 32'd0);
    rd_reg(6, v);
    chk("prio_r6", 32'(v), 32'h42);

    // reset during EXECUCAO aborts the op
    load(1, 8'h10);
    bus.Valido = 1'b1;
    bus.Rd = 3'd3; bus.Rs = 3'd1; bus.Rt = 3'd1;
    tick();
    bus.Valido = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    sb.delete();
    chk("abort_ocupado", 32'(bus.Ocupado), 32'd0);
    chk("abort_entrada1", 32'(bus.Entrada1), 32'd0);
    chk("abort_entrada2", 32'(bus.Entrada2), 32'd0);
    chk("abort_overflow", 32'(bus.Overflow), 32'd0);
    seen = bus.Pronto;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | bus.Pronto;
    end
    chk("abort_pronto", 32'(seen), 32'd0);
    check_all_regs("abort_regs");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
